dmem_responder: RTL and testbench

Data-memory responder for the pipelined processor's dmem port: it receives `address_dmem`, `data` and `wren` and returns `q_dmem`. It backs a word-addressed RAM and a small memory-mapped I/O window. The window holds a transmit FIFO drained by an external valid/ready sink, a status register, a free-running cycle counter and a scratch register. It sits in the wrapper beside the regfile and imem, in place of a bare dmem RAM.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/tx_fifo.sv | 75 +++++++
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory responder.
//   - MMIO word offsets within the 4-word I/O window
//   - STATUS register bit positions
//   - address decode result enumeration and the decode helper
package dmem_pkg;

    localparam logic [1:0] TX_OFS      = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] CYCLES_OFS  = 2'd2;
    localparam logic [1:0] SCRATCH_OFS = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;

    typedef enum logic [1:0] {
        DEC_RAM      = 2'd0,
        DEC_MMIO     = 2'd1,
        DEC_UNMAPPED = 2'd2
    } dec_e;

    // RAM wins if the two regions were ever parameterised to overlap.
    // The window test uses a wrapping subtraction so a base near the top
    // of the address space still decodes correctly.
    function automatic dec_e decode_addr(input logic [31:0] addr,
                                         input int unsigned addr_bits,
                                         input logic [31:0] mmio_base);
        dec_e res;
        if ((addr >> addr_bits) == 32'd0) begin
            res = DEC_RAM;
        end else if ((addr - mmio_base) < 32'd4) begin
            res = DEC_MMIO;
        end else begin
            res = DEC_UNMAPPED;
        end
        return res;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: circular-buffer transmit FIFO.
//   clock, reset       : clock and synchronous active-low reset
//   push, push_data    : enqueue request and word
//   pop                : dequeue request (ignored when empty)
//   head_valid/head_data : current head entry (register-driven, no bypass)
//   count, full, empty : occupancy state before this cycle's push/pop
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and the caller is expected to flag overflow.
module tx_fifo
    import dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [31:0]                   push_data,
    input  logic                          pop,
    output logic                          head_valid,
    output logic [31:0]                   head_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full       = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign count      = count_r;
    assign head_valid = ~empty;
    assign head_data  = mem_r[rd_ptr_r];

    // Accept/consume qualification; when full the write slot equals the
    // head slot, which is safe because the head is read out before the edge.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
    end

    // Storage, pointers and occupancy; reset empties the buffer and zeroes
    // storage so the head word reads 0 afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: processor data-memory port backed by a word RAM and a
// 4-word MMIO window (TX FIFO, STATUS, CYCLES, SCRATCH).
//   clock, reset        : clock and synchronous active-low reset
//   address_dmem, data  : word address and store data
//   wren                : store strobe
//   q_dmem              : registered read data, latency 1
//   tx_valid, tx_data   : FIFO head towards the external sink
//   tx_ready            : sink accepts the head word
//   addr_fault          : one-cycle pulse after an unmapped access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_BITS  = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        addr_fault
);

    localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] BASE_LO = MMIO_BASE[1:0];

    logic [31:0]          ram_r [2**ADDR_BITS];
    logic [31:0]          cycles_r;
    logic [31:0]          scratch_r;
    logic                 ovf_r;
    logic [31:0]          q_dmem_r;
    logic                 addr_fault_r;

    dec_e                 dec_s;
    logic [1:0]           ofs_s;
    logic [ADDR_BITS-1:0] ram_idx_s;
    logic                 ram_we_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 status_we_s;
    logic                 cycles_we_s;
    logic                 scratch_we_s;
    logic                 drop_s;
    logic [31:0]          status_s;
    logic [31:0]          rd_data_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CNT_W-1:0]     fifo_count_s;

    assign q_dmem     = q_dmem_r;
    assign addr_fault = addr_fault_r;

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .push_data  (data),
        .pop        (pop_s),
        .head_valid (tx_valid),
        .head_data  (tx_data),
        .count      (fifo_count_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Address decode and per-target write strobes.
    always_comb begin
        dec_s     = decode_addr(address_dmem, ADDR_BITS, MMIO_BASE);
        ofs_s     = address_dmem[1:0] - BASE_LO;
        ram_idx_s = address_dmem[ADDR_BITS-1:0];
        ram_we_s     = wren & (dec_s == DEC_RAM);
        push_s       = wren & (dec_s == DEC_MMIO) & (ofs_s == TX_OFS);
        status_we_s  = wren & (dec_s == DEC_MMIO) & (ofs_s == STATUS_OFS);
        cycles_we_s  = wren & (dec_s == DEC_MMIO) & (ofs_s == CYCLES_OFS);
        scratch_we_s = wren & (dec_s == DEC_MMIO) & (ofs_s == SCRATCH_OFS);
        pop_s        = tx_valid & tx_ready;
        drop_s       = push_s & fifo_full_s & ~pop_s;
    end

    // STATUS view assembled from live FIFO flags and the sticky overflow.
    always_comb begin
        status_s           = 32'd0;
        status_s[ST_FULL]  = fifo_full_s;
        status_s[ST_EMPTY] = fifo_empty_s;
        status_s[ST_OVF]   = ovf_r;
    end

    // Read mux; every source is pre-edge state, so MMIO reads see values
    // from before this cycle's push, pop or increment.
    always_comb begin
        rd_data_s = 32'd0;
        case (dec_s)
            DEC_RAM: rd_data_s = ram_r[ram_idx_s];
            DEC_MMIO: begin
                case (ofs_s)
                    TX_OFS:      rd_data_s = {{(32-CNT_W){1'b0}}, fifo_count_s};
                    STATUS_OFS:  rd_data_s = status_s;
                    CYCLES_OFS:  rd_data_s = cycles_r;
                    SCRATCH_OFS: rd_data_s = scratch_r;
                    default:     rd_data_s = 32'd0;
                endcase
            end
            default: rd_data_s = 32'd0;
        endcase
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= data;
        end
    end

    // Read data and fault pulse registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_dmem_r     <= 32'd0;
            addr_fault_r <= 1'b0;
        end else begin
            q_dmem_r     <= rd_data_s;
            addr_fault_r <= (dec_s == DEC_UNMAPPED);
        end
    end

    // MMIO registers: free-running CYCLES (a load replaces the increment),
    // SCRATCH, and sticky overflow cleared by writing STATUS bit 2.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycles_r  <= 32'd0;
            scratch_r <= 32'd0;
            ovf_r     <= 1'b0;
        end else begin
            if (cycles_we_s) begin
                cycles_r <= data;
            end else begin
                cycles_r <= cycles_r + 32'd1;
            end
            if (scratch_we_s) begin
                scratch_r <= data;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (status_we_s && data[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Inputs change on the falling edge; each access() spans one rising edge
// and returns on the next falling edge, where the registered outputs for
// that access are compared against hand-computed values.
module tb_dmem_responder;

    localparam logic [31:0] A_TX      = 32'h0000_1000;
    localparam logic [31:0] A_STATUS  = 32'h0000_1001;
    localparam logic [31:0] A_CYCLES  = 32'h0000_1002;
    localparam logic [31:0] A_SCRATCH = 32'h0000_1003;
    localparam logic [31:0] A_UNMAP   = 32'h0000_2000;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        addr_fault;

    int checks;
    int errors;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .addr_fault   (addr_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one access at the falling edge, return after the next one.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        tx_ready     = 1'b0;
        address_dmem = 32'd0;
        data         = 32'd0;
        wren         = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want %h", q_dmem, 32'd0); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", addr_fault); end
        reset = 1'b1;
        access(A_STATUS, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want %h", q_dmem, 32'h2); end
    endtask

    task automatic test_ram();
        access(32'd5, 32'hDEAD_BEEF, 1'b1);
        access(32'd5, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read: got %h want %h", q_dmem, 32'hDEAD_BEEF); end
        access(32'd5, 32'd1, 1'b1);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rdw_old: got %h want %h", q_dmem, 32'hDEAD_BEEF); end
        access(32'd5, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL ram_rdw_new: got %h want %h", q_dmem, 32'd1); end
        access(32'd5, 32'hDEAD_BEEF, 1'b1);
        access(32'd0, 32'h1111_1111, 1'b1);
        access(32'hFFF, 32'h0BAD_F00D, 1'b1);
        access(32'hFFF, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_top_word: got %h want %h", q_dmem, 32'h0BAD_F00D); end
    endtask

    task automatic test_fifo_fill();
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            access(A_TX, i, 1'b1);
        end
        access(A_TX, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd8) begin errors++; $display("FAIL fill_count: got %h want %h", q_dmem, 32'd8); end
        access(A_STATUS, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h5) begin errors++; $display("FAIL fill_status: got %h want %h", q_dmem, 32'h5); end
        checks++; if (tx_data !== 32'd1) begin errors++; $display("FAIL fill_head_stable: got %h want %h", tx_data, 32'd1); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== i) begin
                errors++;
                $display("FAIL drain_word%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, i);
            end
            access(A_SCRATCH, 32'd0, 1'b0);
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid=%b data=%h want valid=0", tx_valid, tx_data); end
        tx_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp_q [8];
        for (int i = 0; i < 8; i++) begin
            access(A_TX, 32'h10 + i, 1'b1);
        end
        checks++; if (tx_data !== 32'h10) begin errors++; $display("FAIL pp_head: got %h want %h", tx_data, 32'h10); end
        tx_ready = 1'b1;
        access(A_TX, 32'hAA, 1'b1);
        tx_ready = 1'b0;
        access(A_TX, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd8) begin errors++; $display("FAIL pp_count: got %h want %h", q_dmem, 32'd8); end
        access(A_STATUS, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h5) begin errors++; $display("FAIL pp_status: got %h want %h", q_dmem, 32'h5); end
        access(A_STATUS, 32'h4, 1'b1);
        access(A_STATUS, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h1) begin errors++; $display("FAIL ovf_clear: got %h want %h", q_dmem, 32'h1); end
        for (int i = 0; i < 7; i++) exp_q[i] = 32'h11 + i;
        exp_q[7] = 32'hAA;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                errors++;
                $display("FAIL pp_drain%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            access(A_SCRATCH, 32'd0, 1'b0);
        end
        tx_ready = 1'b0;
        access(A_STATUS, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h2) begin errors++; $display("FAIL pp_status_empty: got %h want %h", q_dmem, 32'h2); end
    endtask

    task automatic test_cycles();
        logic [31:0] exp_c [4];
        exp_c[0] = 32'hFFFF_FFFE;
        exp_c[1] = 32'hFFFF_FFFF;
        exp_c[2] = 32'h0000_0000;
        exp_c[3] = 32'h0000_0001;
        access(A_CYCLES, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 4; i++) begin
            access(A_CYCLES, 32'd0, 1'b0);
            checks++;
            if (q_dmem !== exp_c[i]) begin
                errors++;
                $display("FAIL cycles%0d: got %h want %h", i, q_dmem, exp_c[i]);
            end
        end
    endtask

    task automatic test_unmapped();
        access(A_SCRATCH, 32'h1234_5678, 1'b1);
        access(A_UNMAP, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0 || addr_fault !== 1'b1) begin errors++; $display("FAIL unmap_read: got q=%h fault=%b want q=0 fault=1", q_dmem, addr_fault); end
        access(A_SCRATCH, 32'd0, 1'b0);
        checks++; if (addr_fault !== 1'b0 || q_dmem !== 32'h1234_5678) begin errors++; $display("FAIL unmap_pulse_end: got fault=%b q=%h want fault=0 q=%h", addr_fault, q_dmem, 32'h1234_5678); end
        access(A_UNMAP, 32'h0000_CAFE, 1'b1);
        checks++; if (addr_fault !== 1'b1 || q_dmem !== 32'd0) begin errors++; $display("FAIL unmap_write: got fault=%b q=%h want fault=1 q=0", addr_fault, q_dmem); end
        access(32'd0, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h1111_1111) begin errors++; $display("FAIL unmap_ram0: got %h want %h", q_dmem, 32'h1111_1111); end
        access(A_TX, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0 || tx_valid !== 1'b0) begin errors++; $display("FAIL unmap_fifo: got count=%h valid=%b want 0/0", q_dmem, tx_valid); end
        access(A_SCRATCH, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h1234_5678) begin errors++; $display("FAIL unmap_scratch: got %h want %h", q_dmem, 32'h1234_5678); end
        access(32'h0000_1004, 32'h0000_0077, 1'b1);
        checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL unmap_above_window: got %b want 1", addr_fault); end
    endtask

    task automatic test_reset_midtransfer();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            access(A_TX, 32'h21 + i, 1'b1);
        end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h21) begin errors++; $display("FAIL rst_pre_valid: got valid=%b data=%h want 1/%h", tx_valid, tx_data, 32'h21); end
        access(A_UNMAP, 32'd0, 1'b0);
        reset = 1'b0;
        access(A_SCRATCH, 32'd0, 1'b0);
        checks++; if (tx_valid !== 1'b0 || tx_data !== 32'd0) begin errors++; $display("FAIL rst_tx: got valid=%b data=%h want 0/0", tx_valid, tx_data); end
        checks++; if (q_dmem !== 32'd0 || addr_fault !== 1'b0) begin errors++; $display("FAIL rst_q_fault: got q=%h fault=%b want 0/0", q_dmem, addr_fault); end
        reset = 1'b1;
        access(A_CYCLES, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL rst_cycles: got %h want 0", q_dmem); end
        access(A_TX, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL rst_count: got %h want 0", q_dmem); end
        access(A_SCRATCH, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL rst_scratch: got %h want 0", q_dmem); end
        access(32'd5, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_ram_kept: got %h want %h", q_dmem, 32'hDEAD_BEEF); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ram();
        test_fifo_fill();
        test_push_pop_full();
        test_cycles();
        test_unmapped();
        test_reset_midtransfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
